// File: rtl/regional_extrema_engine.sv
// rtl/regional_extrema_engine.sv - iterative regional min/max mask engine over an M x N frame
// Optional sweep cap enabled by defining REGEXT_ITER_LIMIT_EN.
module regional_extrema_engine #(
    parameter int M           = 8,
    parameter int N           = 8,
    parameter int PIXEL_WIDTH = 8,
    parameter int MAX_ITER    = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   mode_min,
    input  logic                   conn8,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIXEL_WIDTH-1:0] in_pixel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_mask,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             sweep_cnt,
    output logic                   iter_ovf
);

    localparam int PIXELS = M * N;
    localparam int IDX_W  = $clog2(PIXELS);
    localparam int ROW_W  = $clog2(M);
    localparam int COL_W  = $clog2(N);
`ifdef REGEXT_ITER_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SWEEP, S_CHECK, S_UNLOAD} state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic                   mode_min_q, conn8_q, changed_q;
    logic [7:0]             sweep_cnt_q;
    logic                   iter_ovf_q, busy_q, done_q, in_ready_q;
    logic                   out_valid_q, out_mask_q, out_last_q;
    logic [PIXEL_WIDTH-1:0] pix_q [PIXELS];
    logic [PIXELS-1:0]      mask_q;

    logic                   load_beat, last_idx, last_col, clr, cap_hit;
    logic [PIXEL_WIDTH-1:0] cur_pix, nb_pix;
    logic                   nb_mask;
    logic [IDX_W-1:0]       nb_idx;
    int                     nr, nc;

    assign load_beat = (state_q == S_LOAD) && in_valid && in_ready_q;
    assign last_idx  = (idx_q == IDX_W'(PIXELS - 1));
    assign last_col  = (col_q == COL_W'(N - 1));
    assign idx_d     = idx_q + IDX_W'(1);
    assign col_d     = last_col ? '0 : col_q + COL_W'(1);
    assign row_d     = last_col ? row_q + ROW_W'(1) : row_q;
    assign cap_hit   = LIMIT_EN && (int'(sweep_cnt_q) == MAX_ITER);

    // Neighbours outside the frame are skipped rather than padded.
    always_comb begin
        clr     = 1'b0;
        nr      = 0;
        nc      = 0;
        nb_idx  = '0;
        nb_pix  = '0;
        nb_mask = 1'b0;
        cur_pix = pix_q[idx_q];
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                nr = int'(row_q) + dr;
                nc = int'(col_q) + dc;
                if ((dr != 0 || dc != 0) && (conn8_q || dr == 0 || dc == 0) &&
                    nr >= 0 && nr < M && nc >= 0 && nc < N) begin
                    nb_idx  = IDX_W'(nr * N + nc);
                    nb_pix  = pix_q[nb_idx];
                    nb_mask = mask_q[nb_idx];
                    if (mode_min_q ? (nb_pix < cur_pix) : (nb_pix > cur_pix))
                        clr = 1'b1;
                    if (nb_pix == cur_pix && !nb_mask)
                        clr = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_beat)
            pix_q[idx_q] <= in_pixel;
        if (load_beat && last_idx)
            mask_q <= '1;
        else if (state_q == S_SWEEP && clr)
            mask_q[idx_q] <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            row_q       <= '0;
            col_q       <= '0;
            mode_min_q  <= 1'b0;
            conn8_q     <= 1'b0;
            changed_q   <= 1'b0;
            sweep_cnt_q <= '0;
            iter_ovf_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_mask_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    state_q     <= S_LOAD;
                    mode_min_q  <= mode_min;
                    conn8_q     <= conn8;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b1;
                    sweep_cnt_q <= '0;
                    iter_ovf_q  <= 1'b0;
                    idx_q       <= '0;
                end
                S_LOAD: if (load_beat) begin
                    if (last_idx) begin
                        state_q    <= S_SWEEP;
                        in_ready_q <= 1'b0;
                        idx_q      <= '0;
                        row_q      <= '0;
                        col_q      <= '0;
                        changed_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                S_SWEEP: begin
                    if (clr && mask_q[idx_q])
                        changed_q <= 1'b1;
                    if (last_idx) begin
                        state_q <= S_CHECK;
                        idx_q   <= '0;
                        row_q   <= '0;
                        col_q   <= '0;
                        if (sweep_cnt_q != 8'hFF)
                            sweep_cnt_q <= sweep_cnt_q + 8'd1;
                    end else begin
                        idx_q <= idx_d;
                        row_q <= row_d;
                        col_q <= col_d;
                    end
                end
                S_CHECK: begin
                    if (changed_q && !cap_hit) begin
                        state_q   <= S_SWEEP;
                        changed_q <= 1'b0;
                    end else begin
                        state_q     <= S_UNLOAD;
                        out_valid_q <= 1'b1;
                        out_mask_q  <= mask_q[0];
                        out_last_q  <= 1'b0;
                        iter_ovf_q  <= changed_q && cap_hit;
                    end
                end
                S_UNLOAD: if (out_ready) begin
                    if (out_last_q) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        out_mask_q  <= 1'b0;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        idx_q      <= idx_d;
                        out_mask_q <= mask_q[idx_d];
                        out_last_q <= (idx_d == IDX_W'(PIXELS - 1));
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_mask  = out_mask_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sweep_cnt = sweep_cnt_q;
    assign iter_ovf  = LIMIT_EN ? iter_ovf_q : 1'b0;

endmodule

// File: tb/tb_regional_extrema_engine.sv
// tb/tb_regional_extrema_engine.sv - scoreboard bench for regional_extrema_engine on a 4x4 frame
module tb_regional_extrema_engine;
    localparam int M = 4;
    localparam int N = 4;
    localparam int P = M * N;

    logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, mode_min = 1'b0, conn8 = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] in_pixel = 8'd0;
    logic       in_ready, out_valid, out_mask, out_last, busy, done, iter_ovf;
    logic [7:0] sweep_cnt;

    int vectors = 0;
    int errors  = 0;
    bit exp_mask[$];
    bit exp_last[$];
    int exp_sweeps[$];
    int img[P];
    bit ref_m[P];
    int ref_sweeps;
    bit expect_done = 1'b0;

    always #5 clk = ~clk;

    regional_extrema_engine #(.M(M), .N(N), .PIXEL_WIDTH(8), .MAX_ITER(64)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode_min(mode_min), .conn8(conn8),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_last(out_last),
        .busy(busy), .done(done), .sweep_cnt(sweep_cnt), .iter_ovf(iter_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Repeat whole-frame passes of the extremum rule until nothing changes.
    function automatic void run_model(input bit mn, input bit c8);
        bit changed;
        int dr, dc;
        for (int p = 0; p < P; p++) ref_m[p] = 1'b1;
        ref_sweeps = 0;
        do begin
            changed = 1'b0;
            ref_sweeps++;
            for (int p = 0; p < P; p++) begin
                for (int q = 0; q < P; q++) begin
                    dr = p / N - q / N;
                    dc = p % N - q % N;
                    if (dr < 0) dr = -dr;
                    if (dc < 0) dc = -dc;
                    if (ref_m[p] && (c8 ? (dr <= 1 && dc <= 1 && dr + dc > 0) : (dr + dc == 1))) begin
                        if ((mn ? img[q] < img[p] : img[q] > img[p]) || (img[q] == img[p] && !ref_m[q])) begin
                            ref_m[p] = 1'b0;
                            changed  = 1'b1;
                        end
                    end
                end
            end
        end while (changed && ref_sweeps < 255);
    endfunction

    task automatic push_expect();
        for (int p = 0; p < P; p++) begin
            exp_mask.push_back(ref_m[p]);
            exp_last.push_back(p == P - 1);
        end
        exp_sweeps.push_back(ref_sweeps);
    endtask

    task automatic load_frame(input bit mn, input bit c8, input bit gaps);
        int k = 0;
        int guard = 0;
        @(negedge clk);
        start = 1'b1; mode_min = mn; conn8 = c8;
        while (k < P && guard < 2000) begin
            @(negedge clk);
            start    = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            mode_min = 1'($urandom_range(0, 1));
            conn8    = 1'($urandom_range(0, 1));
            in_valid = !gaps || ($urandom_range(0, 2) != 0);
            in_pixel = 8'(img[k]);
            if (in_valid && in_ready) k++;
            guard++;
        end
        if (k < P) check("load_timeout", k, P);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; in_pixel = 8'($urandom);
    endtask

    task automatic wait_frame();
        int guard = 0;
        while ((busy || exp_mask.size() != 0) && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) check("frame_timeout", guard, 0);
        @(negedge clk);
    endtask

    initial begin : monitor
        bit prev_stall = 1'b0;
        bit pm = 1'b0, pl = 1'b0, el = 1'b0;
        forever begin
            @(negedge clk);
            if (expect_done) begin
                check("done_pulse", done, 1);
                expect_done = 1'b0;
            end else if (done) begin
                check("spurious_done", done, 0);
            end
            if (!reset_n) begin
                prev_stall = 1'b0;
                out_ready  = 1'b0;
            end else begin
                if (prev_stall && out_valid) begin
                    check("stall_mask", out_mask, pm);
                    check("stall_last", out_last, pl);
                end
                out_ready = ($urandom_range(0, 3) != 0);
                if (out_valid && exp_mask.size() == 0) begin
                    check("unexpected_valid", out_valid, 0);
                end else if (out_valid && out_ready) begin
                    el = exp_last.pop_front();
                    check("mask", out_mask, exp_mask.pop_front());
                    check("last", out_last, el);
                    if (el) begin
                        check("sweep_cnt", sweep_cnt, exp_sweeps.pop_front());
                        expect_done = 1'b1;
                    end
                end
                prev_stall = out_valid && !out_ready;
                pm = out_mask;
                pl = out_last;
            end
        end
    end

    initial begin
        bit mn, c8;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sweep_cnt", sweep_cnt, 0);
        check("rst_iter_ovf", iter_ovf, 0);
        check("rst_out_mask", out_mask, 0);
        check("rst_out_last", out_last, 0);
        reset_n = 1'b1;

        for (int p = 0; p < P; p++) begin img[p] = 7; ref_m[p] = 1'b1; end
        ref_sweeps = 1;
        push_expect();
        load_frame(1'b0, 1'b1, 1'b0);
        wait_frame();
        check("sweep_cnt_hold_flat", sweep_cnt, 1);

        for (int p = 0; p < P; p++) begin img[p] = 10; ref_m[p] = 1'b0; end
        img[5] = 20; ref_m[5] = 1'b1; ref_sweeps = 2;
        push_expect();
        load_frame(1'b0, 1'b1, 1'b0);
        wait_frame();
        push_expect();
        load_frame(1'b0, 1'b1, 1'b1);
        wait_frame();
        check("sweep_cnt_hold_peak", sweep_cnt, 2);

        run_model(1'b1, 1'b1);
        push_expect();
        load_frame(1'b1, 1'b1, 1'b1);
        wait_frame();
        check("iter_ovf_clear", iter_ovf, 0);

        for (int p = 0; p < P; p++) img[p] = $urandom_range(0, 2);
        load_frame(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("busy_in_sweep", busy, 1);
        check("in_ready_in_sweep", in_ready, 0);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_sweep_cnt", sweep_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_idle", busy, 0);

        for (int f = 0; f < 14; f++) begin
            for (int p = 0; p < P; p++)
                img[p] = (f % 2 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 255));
            mn = 1'($urandom_range(0, 1));
            c8 = 1'($urandom_range(0, 1));
            run_model(mn, c8);
            push_expect();
            load_frame(mn, c8, 1'($urandom_range(0, 1)));
            wait_frame();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
